// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register outstanding-write tracker for the decode stage.
// Counts in-flight writes per architectural register and holds issue on RAW
// hazards or when a register's counter is saturated. x0 is never tracked.
module id_scoreboard #(
  parameter int INDEX   = 5,
  parameter int NREG    = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               issue_valid_in,
  input  logic               use_rs1_in,
  input  logic               use_rs2_in,
  input  logic [INDEX-1:0]   rs1_in,
  input  logic [INDEX-1:0]   rs2_in,
  input  logic               issue_we_in,
  input  logic [INDEX-1:0]   rd_in,
  output logic               issue_ready_out,
  input  logic               wb_valid_in,
  input  logic [INDEX-1:0]   wb_rd_in,
  input  logic               flush_in,
  output logic [NREG-1:0]    busy_out,
  output logic [STALL_W-1:0] stall_cycles_out,
  output logic               err_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NREG-1:0]            inc_vec, dec_vec;
  logic rs1_hit, rs2_hit, rd_full;
  logic inc, dec, err_hit;

  // Hazard detection straight off registered counters; no write-back bypass.
  always_comb begin
    rs1_hit = use_rs1_in  && (rs1_in != '0) && (cnt[rs1_in] != '0);
    rs2_hit = use_rs2_in  && (rs2_in != '0) && (cnt[rs2_in] != '0);
    rd_full = issue_we_in && (rd_in  != '0) && (cnt[rd_in]  == CNT_MAX);
    issue_ready_out = !(flush_in || rs1_hit || rs2_hit || rd_full);
  end

  // Decode the issue increment and write-back decrement into one-hot vectors.
  always_comb begin
    inc     = issue_valid_in && issue_ready_out && issue_we_in && (rd_in != '0);
    dec     = wb_valid_in && (wb_rd_in != '0);
    inc_vec = inc ? (NREG'(1) << rd_in)    : '0;
    dec_vec = dec ? (NREG'(1) << wb_rd_in) : '0;
    // A write-back to an idle register is an error, unless a flush is
    // discarding the whole state this cycle anyway.
    err_hit = dec && !flush_in && (cnt[wb_rd_in] == '0);
  end

  // Next counter values; flush wins, same-register inc+dec nets to zero
  // except from an idle register where the dec is dropped and only inc lands.
  always_comb begin
    cnt_nxt = cnt;
    cnt_nxt[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      if (flush_in)
        cnt_nxt[i] = '0;
      else if (inc_vec[i] && !dec_vec[i])
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      else if (!inc_vec[i] && dec_vec[i] && (cnt[i] != '0))
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      else if (inc_vec[i] && dec_vec[i] && (cnt[i] == '0))
        cnt_nxt[i] = CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  // Sticky write-back error flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)       err_out <= 1'b0;
    else if (err_hit) err_out <= 1'b1;
  end

  // Saturating count of cycles where a valid instruction was held back.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      stall_cycles_out <= '0;
    else if (issue_valid_in && !issue_ready_out && (stall_cycles_out != '1))
      stall_cycles_out <= stall_cycles_out + STALL_W'(1);
  end

  // Busy flags reflect registered counters directly.
  always_comb begin
    for (int i = 0; i < NREG; i++) busy_out[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with hand-computed expectations.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, use_rs1, use_rs2, issue_we, wb_valid, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        issue_ready, err;
  logic [31:0] busy;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  id_scoreboard dut (
    .clk_in(clk), .rst_in(rst),
    .issue_valid_in(issue_valid), .use_rs1_in(use_rs1), .use_rs2_in(use_rs2),
    .rs1_in(rs1), .rs2_in(rs2), .issue_we_in(issue_we), .rd_in(rd),
    .issue_ready_out(issue_ready),
    .wb_valid_in(wb_valid), .wb_rd_in(wb_rd), .flush_in(flush),
    .busy_out(busy), .stall_cycles_out(stall_cycles), .err_out(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; use_rs1 = 0; use_rs2 = 0; issue_we = 0;
    wb_valid = 0; flush = 0; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
  endtask

  // Advance one clock; inputs then change 1ns after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [4:0] r);
    idle(); issue_valid = 1; issue_we = 1; rd = r; #1;
    chk("issue_wr_ready", issue_ready, 1);
    step();
  endtask

  task automatic wb(input logic [4:0] r);
    idle(); wb_valid = 1; wb_rd = r; step();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", {16'h0, stall_cycles}, 0);
    chk("rst_err", err, 0);
    rst = 0;
    step();

    // RAW on r5, released by write-back in cycle 3
    issue_wr(5);
    for (int c = 1; c <= 3; c++) begin
      idle(); issue_valid = 1; use_rs1 = 1; rs1 = 5;
      if (c == 3) begin wb_valid = 1; wb_rd = 5; end
      #1;
      chk("raw_stall_ready", issue_ready, 0);
      chk("raw_busy5", busy[5], 1);
      step();
    end
    idle(); issue_valid = 1; use_rs1 = 1; rs1 = 5; #1;
    chk("raw_release_ready", issue_ready, 1);
    chk("raw_busy5_clr", busy[5], 0);
    chk("raw_stall_cnt", {16'h0, stall_cycles}, 3);
    step();

    // x0 never tracked
    for (int c = 0; c < 4; c++) begin
      idle(); issue_valid = 1; issue_we = 1; rd = 0; use_rs1 = 1; rs1 = 0; #1;
      chk("x0_ready", issue_ready, 1);
      step();
      chk("x0_busy", busy, 0);
    end
    chk("x0_stall_cnt", {16'h0, stall_cycles}, 3);

    // WAW saturation on r7
    issue_wr(7); issue_wr(7); issue_wr(7);
    chk("sat_busy7", busy[7], 1);
    idle(); issue_valid = 1; issue_we = 1; rd = 7; wb_valid = 1; wb_rd = 7; #1;
    chk("sat_ready", issue_ready, 0);
    step();
    idle(); issue_we = 1; rd = 7; #1;
    chk("sat_release_ready", issue_ready, 1);
    chk("sat_stall_cnt", {16'h0, stall_cycles}, 4);
    wb(7); wb(7);
    chk("sat_drain_busy", busy, 0);
    chk("sat_err", err, 0);

    // Flush discards outstanding writes and the concurrent issue
    issue_wr(3); issue_wr(4);
    chk("fl_busy_pre", busy, 32'h18);
    idle(); flush = 1; issue_valid = 1; issue_we = 1; rd = 10;
    wb_valid = 1; wb_rd = 20; #1;
    chk("fl_ready", issue_ready, 0);
    step();
    chk("fl_busy_post", busy, 0);
    chk("fl_err", err, 0);
    chk("fl_stall_cnt", {16'h0, stall_cycles}, 5);

    // Same-cycle issue and write-back on r9
    issue_wr(9);
    idle(); issue_valid = 1; issue_we = 1; rd = 9; wb_valid = 1; wb_rd = 9; #1;
    chk("same_ready", issue_ready, 1);
    step();
    chk("same_busy9", busy[9], 1);
    chk("same_err", err, 0);
    wb(9);
    chk("same_busy9_clr", busy[9], 0);
    chk("same_err_after_wb", err, 0);
    idle(); issue_valid = 1; issue_we = 1; rd = 9; wb_valid = 1; wb_rd = 9; step();
    chk("same0_err", err, 1);
    chk("same0_busy", busy, 32'h200);
    wb(9);
    chk("same0_drain", busy, 0);
    chk("same0_err_sticky", err, 1);

    // Long RAW stall saturates the counter
    issue_wr(12);
    idle(); issue_valid = 1; use_rs1 = 1; rs1 = 12;
    repeat (70000) step();
    chk("sat_stall", {16'h0, stall_cycles}, 32'hFFFF);
    chk("sat_stall_ready", issue_ready, 0);

    // Asynchronous reset mid-cycle
    #2 rst = 1; #1;
    chk("arst_stall", {16'h0, stall_cycles}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_ready", issue_ready, 1);
    idle();
    step();
    rst = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Tracks outstanding register-file writes for the decode stage and gates instruction issue on RAW hazards.
- Sits beside the decode stage. Consumes the decoded rs1/rs2/rd fields and the register-file write-back strobe, and drives the issue-ready/stall signal back to the fetch/decode pipeline registers.
- Holds a per-register outstanding-write counter, so multiple writes in flight to the same rd (WAW) are tracked without stalling.

Parameters:
- INDEX, 5, register address width.
- NREG, 32, number of architectural registers (2**INDEX).
- CNT_W, 2, width of each outstanding-write counter; maximum in-flight writes per register is 2**CNT_W-1.
- STALL_W, 16, width of the stall-cycle performance counter.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- issue_valid_in  in  1  decode stage holds a valid instruction.
- use_rs1_in  in  1  instruction reads rs1.
- use_rs2_in  in  1  instruction reads rs2.
- rs1_in  in  INDEX  source register 1.
- rs2_in  in  INDEX  source register 2.
- issue_we_in  in  1  instruction writes rd.
- rd_in  in  INDEX  destination register.
- issue_ready_out  out  1  no hazard; instruction may issue this cycle.
- wb_valid_in  in  1  register-file write this cycle (same strobe as the regfile we).
- wb_rd_in  in  INDEX  register written back.
- flush_in  in  1  pipeline flush; discard all outstanding writes.
- busy_out  out  NREG  bit i = register i has at least one outstanding write.
- stall_cycles_out  out  STALL_W  saturating count of cycles with issue_valid_in=1 and issue_ready_out=0.
- err_out  out  1  sticky: a write-back arrived for a register with count 0.

Behaviour:
- Reset, asynchronous: all counters 0, busy_out=0, stall_cycles_out=0, err_out=0.
- Register x0 is never tracked. Its counter stays 0 and it never causes a hazard or a counter change.
- issue_ready_out is combinational from the current (registered) counters. It is 0 if any of the following holds:
  - flush_in=1;
  - use_rs1_in, rs1_in!=0 and cnt[rs1_in]!=0;
  - use_rs2_in, rs2_in!=0 and cnt[rs2_in]!=0;
  - issue_we_in, rd_in!=0 and cnt[rd_in]==max (saturation).
  Otherwise it is 1.
- Issue readiness is independent of issue_valid_in. No write-back bypass: a write-back in cycle N unblocks a dependent instruction from cycle N+1.
- Issue fires when issue_valid_in & issue_ready_out. If issue_we_in and rd_in!=0, cnt[rd_in] increments at the clock edge.
- Write-back: if wb_valid_in and wb_rd_in!=0:
  - cnt[wb_rd_in]>0: decrement.
  - cnt[wb_rd_in]==0: counter unchanged and err_out set (sticky until reset).
- Issue and write-back to the same register in one cycle: net counter unchanged (+1-1). The err check uses the pre-edge count; if it is 0, err_out is set and the counter becomes 1.
- Issue and write-back to different registers in one cycle: both updates apply.
- flush_in=1: all counters cleared at the edge, with priority over issue and write-back. err_out is not raised by a write-back that arrives during flush. Write-backs after a flush for pre-flush writes are the pipeline's responsibility and will flag err_out.
- busy_out[i] = (cnt[i]!=0), derived from registered state with no extra latency.
- stall_cycles_out increments by 1 each cycle with issue_valid_in & !issue_ready_out, saturates at all-ones, and is cleared only by reset.
- Latency: hazard detection 0 cycles (combinational); counter update 1 cycle.

Test Plan:
- Reset, then issue rd=5 (cycle 0), then issue rs1=5 in cycles 1-3 with wb rd=5 in cycle 3 -> ready=0 in cycles 1-3, ready=1 in cycle 4; stall_cycles_out=3; busy_out[5]=1 in cycles 1-3 and 0 in cycle 4.
- Issue rd=0 with rs1=0 repeatedly -> ready stays 1, busy_out stays 0, counters unchanged.
- Three back-to-back issues to rd=7 -> cnt=3, busy_out[7]=1. A fourth issue to rd=7 gets ready=0. One wb rd=7 -> ready=1 next cycle.
- Same-cycle issue rd=9 and wb rd=9 with cnt[9]=1 -> cnt stays 1 and err_out stays 0. Repeat with cnt[9]=0 -> err_out=1, cnt[9]=1.
- Outstanding writes on regs 3 and 4, assert flush_in with a valid issue -> ready=0 that cycle, busy_out=0 the next cycle, issue not recorded.
- Hold a RAW stall for 70000 cycles -> stall_cycles_out saturates at 16'hFFFF. Assert rst_in mid-cycle -> all outputs clear immediately, without waiting for a clock edge.
